// File: rtl/md_pkg.sv
// md_pkg: shared op encodings, scheduler state and default latencies for the HI/LO unit
package md_pkg;
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_e;
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_e;
    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;
endpackage

// File: rtl/md_calc.sv
// md_calc: combinational {hi,lo} result of multiply/divide on the latched operands
module md_calc
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res
);
    logic        mul_s, div_s, b_zero;
    logic [63:0] ea, eb;
    logic [31:0] na, nb, dv, q, r;
    always_comb begin
        mul_s  = op == OP_MULT;
        div_s  = op == OP_DIV;
        ea     = {{32{mul_s & a[31]}}, a};
        eb     = {{32{mul_s & b[31]}}, b};
        // signed divide works on magnitudes; 0x8000_0000 / -1 falls out as 0x8000_0000 rem 0
        na     = (div_s & a[31]) ? -a : a;
        nb     = (div_s & b[31]) ? -b : b;
        b_zero = b == 32'd0;
        dv     = b_zero ? 32'd1 : nb;
        q      = na / dv;
        r      = na % dv;
        res    = ~op[1] ? ea * eb :
                 b_zero ? {a, 32'hFFFF_FFFF} :
                 {(div_s & a[31]) ? -r : r, (div_s & (a[31] ^ b[31])) ? -q : q};
    end
endmodule

// File: rtl/md_sched.sv
// md_sched: HI/LO multiply/divide scheduler with fixed-latency FSM and pipeline stall
// Define MD_SCHED_CANCEL_EN to let a flush abort an operation in flight.
module md_sched
    import md_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
`ifdef MD_SCHED_CANCEL_EN
    localparam bit CANCEL = 1'b1;
`else
    localparam bit CANCEL = 1'b0;
`endif
    md_state_e   state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [63:0] res;
    logic        acc;
    md_calc u_calc (.op(op_q), .a(a_q), .b(b_q), .res(res));
    assign busy  = state_q == S_RUN;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign stall = md_use & (busy | (start & ~op[2] & ~flush));
    always_comb begin
        acc     = start & ~flush & ~busy;
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == S_IDLE) begin
            if (acc && !op[2]) begin
                state_d = S_RUN;
                cnt_d   = op[1] ? 8'(DIV_LAT - 1) : 8'(MUL_LAT - 1);
                op_d    = op;
                a_d     = rs_val;
                b_d     = rt_val;
            end
            hi_d = (acc && op == OP_MTHI) ? rs_val : hi_q;
            lo_d = (acc && op == OP_MTLO) ? rs_val : lo_q;
        end else if (CANCEL && flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (cnt_q == '0) begin
            state_d      = S_IDLE;
            {hi_d, lo_d} = res;
        end else begin
            cnt_d = cnt_q - 8'd1;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: randomized scoreboard bench for md_sched against an arithmetic reference model
`timescale 1ns/1ps
module tb_md_sched;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;
    logic        clk, reset, start, md_use, flush, busy, stall;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val, hi, lo;
    typedef struct {
        logic [31:0] ohi, olo, hi, lo;
        int          lat;
    } exp_t;
    exp_t        exp_q[$];
    int          checks = 0, errs = 0;
    logic [31:0] m_hi = 0, m_lo = 0;
    md_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .md_use(md_use), .flush(flush), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );
    initial clk = 0;
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a)), sb = longint'($signed(b)), sq, sr;
        logic [63:0] ua = {32'd0, a}, ub = {32'd0, b}, uq, ur;
        if (o >= 3'd2 && b == 0) return {a, 32'hFFFF_FFFF};
        case (o)
            3'd0: return 64'(sa * sb);
            3'd1: return ua * ub;
            3'd2: begin sq = sa / sb; sr = sa % sb; return {sr[31:0], sq[31:0]}; end
            default: begin uq = ua / ub; ur = ua % ub; return {ur[31:0], uq[31:0]}; end
        endcase
    endfunction
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction
    // monitor: hi/lo must hold during a run, and the result appears when busy drops
    initial begin
        int  run;
        bit  prev;
        exp_t e;
        run = 0;
        prev = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset) begin
                prev = 0;
                run  = 0;
            end else begin
                if (busy) begin
                    run++;
                    if (exp_q.size() == 0) chk("sb_unexpected_busy", 64'(exp_q.size()), 64'd1);
                    else begin
                        chk("hold_hi", hi, exp_q[0].ohi);
                        chk("hold_lo", lo, exp_q[0].olo);
                    end
                end else if (prev) begin
                    if (exp_q.size() == 0) chk("sb_empty_commit", 64'(exp_q.size()), 64'd1);
                    else begin
                        e = exp_q.pop_front();
                        chk("commit_hi", hi, e.hi);
                        chk("commit_lo", lo, e.lo);
                        chk("busy_cycles", 64'(run), 64'(e.lat));
                    end
                    run = 0;
                end
                prev = busy;
            end
        end
    end
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic u, input int flush_at, input bit poke);
        int          lat, cyc;
        bit          cancel;
        logic [63:0] r;
        exp_t        e;
        start = 1; op = o; rs_val = a; rt_val = b; md_use = u; flush = 0;
        #1 chk("stall_accept", stall, u);
        lat = o[1] ? DIV_LAT : MUL_LAT;
        r = model(o, a, b);
        cancel = 0;
`ifdef MD_SCHED_CANCEL_EN
        cancel = flush_at > 0 && flush_at <= lat;
`endif
        e.ohi = m_hi;
        e.olo = m_lo;
        e.hi  = cancel ? m_hi : r[63:32];
        e.lo  = cancel ? m_lo : r[31:0];
        e.lat = cancel ? flush_at : lat;
        exp_q.push_back(e);
        if (!cancel) {m_hi, m_lo} = r;
        cyc = 0;
        @(negedge clk);
        start = 0;
        while (busy && cyc < 40) begin
            cyc++;
            flush = cyc == flush_at;
            if (poke && cyc == 2) begin
                start = 1; op = 3'd5; rs_val = $urandom;
            end else start = 0;
            #1 chk("stall_run", stall, u);
            @(negedge clk);
        end
        start = 0;
        flush = 0;
        chk("drv_busy_len", 64'(cyc), 64'(e.lat));
        chk("idle_hi", hi, m_hi);
        chk("idle_lo", lo, m_lo);
    endtask
    task automatic mv(input logic [2:0] o, input logic [31:0] a);
        start = 1; op = o; rs_val = a; rt_val = $urandom; md_use = 1; flush = 0;
        #1 chk("stall_move", stall, 1'b0);
        if (o == 3'd4) m_hi = a;
        else m_lo = a;
        @(negedge clk);
        start = 0;
        chk("move_busy", busy, 1'b0);
        chk("move_hi", hi, m_hi);
        chk("move_lo", lo, m_lo);
    endtask
    task automatic ignored(input logic [2:0] o, input logic fl);
        start = 1; op = o; rs_val = $urandom; rt_val = $urandom; md_use = 1; flush = fl;
        #1 chk("stall_ignored", stall, !o[2] && !fl);
        @(negedge clk);
        start = 0;
        flush = 0;
        chk("ign_busy", busy, 1'b0);
        @(negedge clk);
        chk("ign_busy2", busy, 1'b0);
        chk("ign_hi", hi, m_hi);
        chk("ign_lo", lo, m_lo);
    endtask
    initial begin
        exp_t e;
        logic [2:0] o;
        reset = 0; start = 0; op = 0; rs_val = 0; rt_val = 0; md_use = 1; flush = 0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", stall, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1;
        mv(3'd5, 32'h1234);
        chk("mtlo_1234", lo, 32'h1234);
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1, 0, 0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        run_op(3'd3, 32'd100, 32'd7, 1, 0, 0);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);
        run_op(3'd2, 32'd7, 32'd0, 0, 0, 0);
        chk("div0_lo", lo, 32'hFFFF_FFFF);
        chk("div0_hi", hi, 32'd7);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 0);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'd0);
        ignored(3'd0, 1'b1);
        ignored(3'd6, 1'b0);
        ignored(3'd7, 1'b0);
        mv(3'd4, 32'hAAAA);
        mv(3'd5, 32'h5555);
        run_op(3'd2, 32'hFFFF_FFEC, 32'd6, 1, 3, 0);
`ifdef MD_SCHED_CANCEL_EN
        chk("cancel_hi", hi, 32'hAAAA);
        chk("cancel_lo", lo, 32'h5555);
`else
        chk("nocancel_hi", hi, 32'hFFFF_FFFE);
        chk("nocancel_lo", lo, 32'hFFFF_FFFD);
`endif
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 5));
            if (o[2]) mv(o, pick());
            else run_op(o, pick(), pick(), 1'($urandom_range(0, 1)), 0, $urandom_range(0, 3) == 0);
        end
        mv(3'd4, 32'hDEAD);
        start = 1; op = 3'd2; rs_val = 32'd50; rt_val = 32'd3; md_use = 1;
        e.ohi = m_hi; e.olo = m_lo; e.hi = 0; e.lo = 0; e.lat = DIV_LAT;
        exp_q.push_back(e);
        @(negedge clk);
        start = 0;
        @(negedge clk);
        reset = 0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_stall", stall, 1'b0);
        exp_q.delete();
        m_hi = 0;
        m_lo = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_rst_busy", busy, 1'b0);
        end
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_lo", lo, 32'd0);
        run_op(3'd1, 32'd6, 32'd7, 0, 0, 0);
        chk("final_lo", lo, 32'd42);
        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end
endmodule

// File: doc/md_sched.md
MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-003 start  input  1  E-stage multiply/divide or move-to instruction issues this cycle.
REQ-004 op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved, treated as no-op.
REQ-005 rs_val  input  32  forwarded rs operand (dividend, multiplicand, move source).
REQ-006 rt_val  input  32  forwarded rt operand (divisor, multiplier).
REQ-007 md_use  input  1  E-stage instruction touches HI/LO (any op above, or MFHI/MFLO).
REQ-008 flush  input  1  exception/interrupt taken at M stage; cancels the E-stage instruction.
REQ-009 busy  output  1  operation in flight.
REQ-010 stall  output  1  hold F/D/E, bubble into E/M register.
REQ-011 hi  output  32  architectural HI.
REQ-012 lo  output  32  architectural LO.
REQ-013 Parameters: MUL_LAT default 5, multiply cycles from accept to commit; DIV_LAT default 10, divide cycles from accept to commit.

Function
REQ-014 Accept condition: start & ~flush & ~busy; start with flush high, or while busy, is ignored.
REQ-015 States IDLE and RUN; IDLE->RUN on accepted op 0-3; RUN->IDLE when count reaches 0.
REQ-016 On accept, operands latch into shadow regs; count loads MUL_LAT-1 (ops 0-1) or DIV_LAT-1 (ops 2-3).
REQ-017 RUN: count decrements by 1 per cycle; in the cycle count==0, shadow result commits to hi/lo and busy falls next edge.
REQ-018 busy high exactly MUL_LAT or DIV_LAT cycles, starting the cycle after accept.
REQ-019 MULT: {hi,lo} = signed 32x32 -> 64-bit product; MULTU unsigned.
REQ-020 DIV: lo = signed quotient truncated toward zero, hi = remainder with sign of dividend; DIVU unsigned.
REQ-021 Divide by zero: lo = 32'hFFFF_FFFF, hi = rs_val; no exception raised.
REQ-022 Signed 0x8000_0000 / -1: lo = 0x8000_0000, hi = 0.
REQ-023 MTHI/MTLO accepted in IDLE write hi/lo at the next edge; busy stays low.
REQ-024 stall = md_use & (busy | (start & op<=3 & ~flush)); combinational, asserted in the accept cycle.
REQ-025 hi/lo unchanged except at commit or MTHI/MTLO write.

Reset
REQ-026 reset low: state IDLE, count 0, busy 0, hi 0, lo 0, shadow regs 0; stall low.
REQ-027 reset low mid-RUN aborts the operation; no commit after release.
REQ-028 First accept possible on the first rising edge after reset deasserts.

Configuration
REQ-029 Macro MD_SCHED_CANCEL_EN.
REQ-030 Defined: flush high in RUN returns to IDLE next edge, busy falls, hi/lo keep pre-operation values.
REQ-031 Undefined: flush affects only the accept gate; a RUN operation always completes and commits.

Structure
REQ-032 Shared package md_pkg: op encodings, state enum, default MUL_LAT/DIV_LAT constants.
REQ-033 Sub-module md_calc: combinational 64-bit multiply/divide result from op and shadow operands; md_sched holds FSM, counter, HI/LO.

Verification
REQ-034 MULT rs=0xFFFF_FFFE, rt=3 -> busy 5 cycles, then hi=0xFFFF_FFFF, lo=0xFFFF_FFFA.
REQ-035 DIVU rs=100, rt=7 -> busy 10 cycles, lo=14, hi=2; md_use held high -> stall high for all 11 cycles including accept.
REQ-036 DIV rs=7, rt=0 -> lo=0xFFFF_FFFF, hi=7; DIV 0x8000_0000/0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
REQ-037 start MULT with flush=1 -> busy never rises, hi/lo unchanged; MTLO rs=0x1234 in IDLE -> lo=0x1234 next cycle, busy 0.
REQ-038 flush at cycle 3 of DIV run -> with MD_SCHED_CANCEL_EN IDLE next cycle, hi/lo old; without it commit at cycle 10.
REQ-039 reset low during RUN cycle 2 -> busy, hi, lo read 0 immediately; no commit after release.
